// File: rtl/drum_pkg.sv
// Shared types and default sizes for the drum machine pipeline.
// The pattern array type is common to user_interface and step_sequencer.
package drum_pkg;

  localparam int unsigned PATTERN_WIDTH_DEF = 8;
  localparam int unsigned COUNT_WIDTH_DEF   = 4;
  localparam int unsigned DRUM_COUNT_DEF    = 5;
  localparam int unsigned DIV_WIDTH_DEF     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  typedef logic [PATTERN_WIDTH_DEF-1:0] pattern_arr_t [DRUM_COUNT_DEF];

endpackage

// File: rtl/tempo_divider.sv
// Free-running step-rate divider: tick_o strobes when the count matches div_i.
// div_i is compared live; a count above div_i rolls through the full range.
module tempo_divider
  import drum_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 w_hit;

  assign w_hit  = (r_div_cnt == div_i);
  assign tick_o = w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (clr_i || w_hit) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Pattern playback: steps through double-buffered per-drum patterns at the
// programmed tempo and emits one-cycle drum triggers plus a bar pulse.
module step_sequencer
  import drum_pkg::*;
#(
  parameter int unsigned PATTERN_WIDTH = PATTERN_WIDTH_DEF,
  parameter int unsigned COUNT_WIDTH   = COUNT_WIDTH_DEF,
  parameter int unsigned DRUM_COUNT    = DRUM_COUNT_DEF,
  parameter int unsigned DIV_WIDTH     = DIV_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PATTERN_WIDTH-1:0] pattern_i [DRUM_COUNT],
  input  logic                     pattern_valid_i,
  output logic                     pattern_ready_o,
  input  logic                     run_i,
  input  logic [DIV_WIDTH-1:0]     tempo_div_i,
  input  logic [DRUM_COUNT-1:0]    mute_i,
  output logic [DRUM_COUNT-1:0]    trig_o,
  output logic [COUNT_WIDTH-1:0]   step_o,
  output logic                     bar_o,
  output logic                     running_o
);

  seq_state_t               r_state;
  seq_state_t               w_state_nxt;
  logic [COUNT_WIDTH-1:0]   r_step;
  logic [COUNT_WIDTH-1:0]   w_step_nxt;
  logic [COUNT_WIDTH-1:0]   w_play_step;
  logic                     w_tick;
  logic                     w_div_tick;
  logic                     w_div_clr;
  logic                     w_last;
  logic                     w_accept;
  logic                     w_commit;
  logic [DRUM_COUNT-1:0]    w_hits;
  logic [PATTERN_WIDTH-1:0] r_active  [DRUM_COUNT];
  logic [PATTERN_WIDTH-1:0] r_pending [DRUM_COUNT];
  logic                     r_pend_full;
  logic [DRUM_COUNT-1:0]    r_trig;
  logic [COUNT_WIDTH-1:0]   r_step_out;
  logic                     r_bar;

  tempo_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tempo_divider (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_div_clr),
    .div_i  (tempo_div_i),
    .tick_o (w_div_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving IDLE forces a tick so step 0 plays on the first RUN cycle
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_div_clr   = 1'b1;
    w_play_step = r_step;
    case (r_state)
      IDLE: begin
        w_play_step = '0;
        if (run_i) begin
          w_state_nxt = RUN;
          w_tick      = 1'b1;
        end
      end
      RUN: begin
        if (run_i) begin
          w_div_clr = 1'b0;
          w_tick    = w_div_tick;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_last = (w_play_step == COUNT_WIDTH'(PATTERN_WIDTH - 1));

  always_comb begin
    w_step_nxt = r_step;
    if (w_tick) begin
      w_step_nxt = w_last ? '0 : (w_play_step + COUNT_WIDTH'(1));
    end else if (!run_i) begin
      w_step_nxt = '0;
    end
  end

  always_comb begin
    w_hits = '0;
    for (int d = 0; d < int'(DRUM_COUNT); d++) begin
      w_hits[d] = 1'(r_active[d] >> w_play_step) & ~mute_i[d];
    end
  end

  // Pending set swaps in at bar end, or immediately when playback stops
  assign w_accept = pattern_valid_i & ~r_pend_full;
  assign w_commit = r_pend_full & ((w_tick & w_last) | ((r_state == RUN) & ~run_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step      <= '0;
      r_pend_full <= 1'b0;
      for (int d = 0; d < int'(DRUM_COUNT); d++) begin
        r_active[d]  <= '0;
        r_pending[d] <= '0;
      end
    end else begin
      r_step <= w_step_nxt;
      if (w_commit) begin
        for (int d = 0; d < int'(DRUM_COUNT); d++) begin
          r_active[d] <= r_pending[d];
        end
      end else if (w_accept && (r_state == IDLE)) begin
        for (int d = 0; d < int'(DRUM_COUNT); d++) begin
          r_active[d] <= pattern_i[d];
        end
      end
      if (w_accept && (r_state == RUN)) begin
        r_pend_full <= 1'b1;
        for (int d = 0; d < int'(DRUM_COUNT); d++) begin
          r_pending[d] <= pattern_i[d];
        end
      end else if (w_commit) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trig     <= '0;
      r_bar      <= 1'b0;
      r_step_out <= '0;
    end else begin
      r_trig <= w_tick ? w_hits : '0;
      r_bar  <= w_tick & (w_play_step == '0);
      if (w_tick) begin
        r_step_out <= w_play_step;
      end else if (!run_i) begin
        r_step_out <= '0;
      end
    end
  end

  assign trig_o          = r_trig;
  assign bar_o           = r_bar;
  assign step_o          = r_step_out;
  assign running_o       = (r_state == RUN);
  assign pattern_ready_o = ~r_pend_full;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed and randomized checks of step_sequencer against a step/bar-level
// reference model kept in the bench.
module tb_step_sequencer;
  import drum_pkg::*;

  localparam int unsigned PW = PATTERN_WIDTH_DEF;
  localparam int unsigned CW = COUNT_WIDTH_DEF;
  localparam int unsigned DC = DRUM_COUNT_DEF;
  localparam int unsigned DW = DIV_WIDTH_DEF;

  logic          clk;
  logic          rst;
  pattern_arr_t  pattern_i;
  logic          pattern_valid_i;
  logic          pattern_ready_o;
  logic          run_i;
  logic [DW-1:0] tempo_div_i;
  logic [DC-1:0] mute_i;
  logic [DC-1:0] trig_o;
  logic [CW-1:0] step_o;
  logic          bar_o;
  logic          running_o;

  step_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .pattern_i       (pattern_i),
    .pattern_valid_i (pattern_valid_i),
    .pattern_ready_o (pattern_ready_o),
    .run_i           (run_i),
    .tempo_div_i     (tempo_div_i),
    .mute_i          (mute_i),
    .trig_o          (trig_o),
    .step_o          (step_o),
    .bar_o           (bar_o),
    .running_o       (running_o)
  );

  // Reference model: playing flag, clocks since last step, bar position, two pattern banks
  logic [PW-1:0] m_act  [DC];
  logic [PW-1:0] m_pend [DC];
  bit            m_pfull;
  bit            m_run;
  int unsigned   m_cnt;
  int            m_step;
  logic [DC-1:0] e_trig;
  int            e_step;
  bit            e_bar;

  int n_cmp;
  int n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    for (int d = 0; d < int'(DC); d++) begin
      m_act[d]  = '0;
      m_pend[d] = '0;
    end
    m_pfull = 0;
    m_run   = 0;
    m_cnt   = 0;
    m_step  = 0;
    e_trig  = '0;
    e_step  = 0;
    e_bar   = 0;
  endfunction

  function automatic void model_edge();
    bit tick;
    bit accept;
    int play;
    accept = pattern_valid_i && !m_pfull;
    tick   = 0;
    play   = m_step;
    if (!m_run) begin
      play = 0;
      tick = run_i;
    end else if (run_i) begin
      tick = (m_cnt == int'(tempo_div_i));
    end
    if (tick) begin
      for (int d = 0; d < int'(DC); d++) e_trig[d] = m_act[d][play] & ~mute_i[d];
      e_bar  = (play == 0);
      e_step = play;
    end else begin
      e_trig = '0;
      e_bar  = 0;
      if (!run_i) e_step = 0;
    end
    if (m_pfull && ((tick && play == int'(PW) - 1) || (m_run && !run_i))) begin
      for (int d = 0; d < int'(DC); d++) m_act[d] = m_pend[d];
      m_pfull = 0;
    end
    if (accept) begin
      if (!m_run) begin
        for (int d = 0; d < int'(DC); d++) m_act[d] = pattern_i[d];
      end else begin
        for (int d = 0; d < int'(DC); d++) m_pend[d] = pattern_i[d];
        m_pfull = 1;
      end
    end
    if (!run_i || tick) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % (1 << DW);
    if (tick) m_step = (play == int'(PW) - 1) ? 0 : play + 1;
    else if (!run_i) m_step = 0;
    m_run = run_i;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
    check("trig",    32'(trig_o),          32'(e_trig));
    check("step",    32'(step_o),          32'(e_step));
    check("bar",     32'(bar_o),           32'(e_bar));
    check("running", 32'(running_o),       32'(m_run));
    check("ready",   32'(pattern_ready_o), 32'(!m_pfull));
  endtask

  // Async reset pulse between clock edges; outputs must clear without waiting for a clock
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_trig",    32'(trig_o),          32'(0));
    check("rst_step",    32'(step_o),          32'(0));
    check("rst_bar",     32'(bar_o),           32'(0));
    check("rst_running", 32'(running_o),       32'(0));
    check("rst_ready",   32'(pattern_ready_o), 32'(1));
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  task automatic clear_patterns();
    for (int d = 0; d < int'(DC); d++) pattern_i[d] = '0;
  endtask

  initial begin
    bit found;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    run_i = 1'b0;
    pattern_valid_i = 1'b0;
    tempo_div_i = '0;
    mute_i = '0;
    clear_patterns();
    model_reset();
    #12;
    check("reset_trig",    32'(trig_o),          32'(0));
    check("reset_step",    32'(step_o),          32'(0));
    check("reset_bar",     32'(bar_o),           32'(0));
    check("reset_running", 32'(running_o),       32'(0));
    check("reset_ready",   32'(pattern_ready_o), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    clk_step();

    // IDLE load, tempo 4 clocks per step
    tempo_div_i = DW'(3);
    pattern_i[0] = 8'b0000_0101;
    pattern_valid_i = 1'b1;
    clk_step();
    pattern_valid_i = 1'b0;
    run_i = 1'b1;
    clk_step();
    check("s2_first_trig", 32'(trig_o), 32'(5'b00001));
    check("s2_first_bar",  32'(bar_o),  32'(1));
    for (int i = 0; i < 8; i++) begin
      clk_step();
      if (i == 3) check("s2_step1", 32'(step_o), 32'(1));
      if (i < 7) check("s2_gap", 32'(trig_o), 32'(0));
    end
    check("s2_step2_trig", 32'(trig_o), 32'(5'b00001));
    check("s2_step2_idx",  32'(step_o), 32'(2));

    // Load while running at step 3; must wait for the next bar
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      clk_step();
      found = (step_o == CW'(3));
    end
    check("s3_reach_step3", 32'(found), 32'(1));
    pattern_i[1] = 8'hFF;
    pattern_valid_i = 1'b1;
    clk_step();
    pattern_valid_i = 1'b0;
    check("s3_ready_low", 32'(pattern_ready_o), 32'(0));
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      clk_step();
      found = bar_o;
      if (!found) check("s3_no_drum1", 32'(trig_o[1]), 32'(0));
    end
    check("s3_bar_seen", 32'(found), 32'(1));
    check("s3_new_bar_trig", 32'(trig_o), 32'(5'b00011));

    // valid held while a load is pending: next accept only right after the commit
    pattern_i[2] = 8'h0F;
    pattern_valid_i = 1'b1;
    clk_step();
    pattern_i[3] = 8'hAA;
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      clk_step();
      found = pattern_ready_o;
    end
    check("s6_ready_back", 32'(found), 32'(1));
    check("s6_commit_at_step7", 32'(step_o), 32'(7));
    clk_step();
    check("s6_second_accept", 32'(pattern_ready_o), 32'(0));
    pattern_valid_i = 1'b0;

    // Stop at step 5 mid-count, then restart
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      clk_step();
      found = (step_o == CW'(5));
    end
    check("s5_reach_step5", 32'(found), 32'(1));
    clk_step();
    run_i = 1'b0;
    clk_step();
    check("s5_stop_trig",    32'(trig_o),    32'(0));
    check("s5_stop_step",    32'(step_o),    32'(0));
    check("s5_stop_running", 32'(running_o), 32'(0));
    for (int k = 0; k < 6; k++) begin
      clk_step();
      check("s5_idle_trig", 32'(trig_o), 32'(0));
    end
    run_i = 1'b1;
    clk_step();
    check("s5_restart_bar",  32'(bar_o),  32'(1));
    check("s5_restart_step", 32'(step_o), 32'(0));

    // Tick every cycle, all drums on, drum 2 muted
    run_i = 1'b0;
    clk_step();
    for (int d = 0; d < int'(DC); d++) pattern_i[d] = 8'hFF;
    pattern_valid_i = 1'b1;
    clk_step();
    pattern_valid_i = 1'b0;
    tempo_div_i = '0;
    mute_i = 5'b00100;
    run_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      check("s4_trig", 32'(trig_o), 32'(5'b11011));
      check("s4_step", 32'(step_o), 32'(i % 8));
      if (i % 8 == 0) check("s4_bar", 32'(bar_o), 32'(1));
    end

    // Reset while running
    mid_reset();
    run_i = 1'b0;
    mute_i = '0;
    clk_step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) run_i = ~run_i;
      if (!run_i && $urandom_range(3) == 0) tempo_div_i = DW'($urandom_range(3));
      pattern_valid_i = ($urandom_range(7) == 0);
      for (int d = 0; d < int'(DC); d++) pattern_i[d] = PW'($urandom);
      if ($urandom_range(15) == 0) mute_i = DC'($urandom);
      clk_step();
      if ($urandom_range(499) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
